cache_line_writeback: RTL and testbench

- Write-back engine on the memory side of the set-associative data cache: the outbound counterpart of the block-fill path (dataBlock/dataTag/dataValid).
- Accepts one evicted 512-bit line plus its tag and set.
- Serializes the line as BLOCK_WORDS 32-bit word writes on a valid/ack memory write port, generating each word's byte address.
- Pulses a completion strobe when the last word has been acknowledged.

---
 rtl/cache_line_writeback.sv | 169 ++++++++++++++++
 tb/tb_cache_line_writeback.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_writeback.sv
// Write-back engine: serializes one evicted cache line into BLOCK_WORDS word writes.
// Latency: accept edge + one cycle per acknowledged word + one DONE cycle (BLOCK_WORDS+2 minimum).
// Backpressure: wbReady only in IDLE; each word is held stable on the memory port until memAck.
//
// Ports:
//   clk, reset        - clock and asynchronous active-low reset
//   wbValid/wbReady   - line handshake; wbBlock/wbTag/wbSet captured on accept
//   memReq/memAck     - word write handshake; memAddr/memWData/memLast describe the current word
//   wbDone            - one-cycle pulse after the final word is acknowledged
//   wbError           - sticky timeout flag (CACHE_WB_TIMEOUT_EN only, otherwise tied 0)
//
// Optional feature: define CACHE_WB_TIMEOUT_EN to abandon a line when a word waits
// TIMEOUT cycles without memAck.
module cache_line_writeback #(
  parameter int BLOCK_WORDS = 16,
  parameter int WORD_BITS   = 32,
  parameter int TAG_BITS    = 25,
  parameter int SET_BITS    = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wbValid,
  output logic                             wbReady,
  input  logic [BLOCK_WORDS*WORD_BITS-1:0] wbBlock,
  input  logic [TAG_BITS-1:0]              wbTag,
  input  logic [SET_BITS-1:0]              wbSet,
  output logic                             memReq,
  input  logic                             memAck,
  output logic [31:0]                      memAddr,
  output logic [WORD_BITS-1:0]             memWData,
  output logic                             memLast,
  output logic                             wbDone,
  output logic                             wbError
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Line held as an array of words so word selection is a plain index.
  logic [1:0]                              state_q, state_d;
  logic [IDX_W-1:0]                        word_idx_q, word_idx_d;
  logic [BLOCK_WORDS-1:0][WORD_BITS-1:0]   line_q, line_d;
  logic [TAG_BITS-1:0]                     tag_q, tag_d;
  logic [SET_BITS-1:0]                     set_q, set_d;
  logic [31:0]                             mem_addr_q, mem_addr_d;
  logic [WORD_BITS-1:0]                    mem_wdata_q, mem_wdata_d;
  logic [IDX_W-1:0]                        next_idx;

`ifdef CACHE_WB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    line_d      = line_q;
    tag_d       = tag_q;
    set_d       = set_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    next_idx    = word_idx_q + 1'b1;
`ifdef CACHE_WB_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    err_d       = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (wbValid) begin
          line_d      = wbBlock;
          tag_d       = wbTag;
          set_d       = wbSet;
          word_idx_d  = '0;
          // Word 0 is presented straight from the inputs so SEND starts with a valid word.
          mem_addr_d  = {wbTag, wbSet, {IDX_W{1'b0}}, 2'b00};
          mem_wdata_d = wbBlock[WORD_BITS-1:0];
          state_d     = ST_SEND;
`ifdef CACHE_WB_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
        end
      end

      ST_SEND: begin
        if (memAck) begin
`ifdef CACHE_WB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
          if (word_idx_q == LAST_IDX) begin
            // Address/data hold the last word; memReq drops with the state change.
            state_d = ST_DONE;
          end else begin
            word_idx_d  = next_idx;
            mem_addr_d  = {tag_q, set_q, next_idx, 2'b00};
            mem_wdata_d = line_q[next_idx];
          end
        end
`ifdef CACHE_WB_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          // TIMEOUT consecutive un-acked cycles on this word: drop the line.
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      word_idx_q  <= '0;
      line_q      <= '0;
      tag_q       <= '0;
      set_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      line_q      <= line_d;
      tag_q       <= tag_d;
      set_q       <= set_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef CACHE_WB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign wbError = err_q;
`else
  assign wbError = 1'b0;
`endif

  assign wbReady  = (state_q == ST_IDLE);
  assign memReq   = (state_q == ST_SEND);
  assign memLast  = memReq && (word_idx_q == LAST_IDX);
  assign wbDone   = (state_q == ST_DONE);
  assign memAddr  = mem_addr_q;
  assign memWData = mem_wdata_q;

endmodule

// File: tb/tb_cache_line_writeback.sv
module tb_cache_line_writeback;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         wbValid;
  logic         wbReady;
  logic [511:0] wbBlock;
  logic [24:0]  wbTag;
  logic [0:0]   wbSet;
  logic         memReq;
  logic         memAck;
  logic [31:0]  memAddr;
  logic [31:0]  memWData;
  logic         memLast;
  logic         wbDone;
  logic         wbError;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  exp_t exp_q[$];
  int   lat_q[$];

  // stall control for the ack driver
  logic       ack_off = 1'b0;
  int         stall_left = 0;
  logic [3:0] stall_word = 4'd5;

  cache_line_writeback #(
    .BLOCK_WORDS(16), .WORD_BITS(32), .TAG_BITS(25), .SET_BITS(1), .TIMEOUT(4)
  ) dut (
    .clk(clk), .reset(reset), .wbValid(wbValid), .wbReady(wbReady),
    .wbBlock(wbBlock), .wbTag(wbTag), .wbSet(wbSet),
    .memReq(memReq), .memAck(memAck), .memAddr(memAddr), .memWData(memWData),
    .memLast(memLast), .wbDone(wbDone), .wbError(wbError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic l);
    exp_t e;
    e.addr = a; e.data = d; e.last = l;
    exp_q.push_back(e);
  endtask

  // Present a line and return on the first SEND cycle (#1 after the accept edge).
  task automatic send_line(input logic [24:0] tag, input logic set, input logic [511:0] blk);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    wbTag = tag; wbSet = set; wbBlock = blk; wbValid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (wbReady) begin ok = 1; break; end
    end
    chk("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    wbValid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (exp_q.size() == 0 && lat_q.size() == 0) begin ok = 1; break; end
      @(posedge clk);
    end
    chk("drain_timeout", 32'(ok), 32'd1);
    repeat (2) @(posedge clk);
  endtask

  // Ack driver: acks whenever a request is up, except for programmed stalls.
  initial begin
    memAck = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ack_off) memAck = 1'b0;
      else if (memReq && memAddr[5:2] == stall_word && stall_left > 0) begin
        memAck = 1'b0;
        stall_left--;
      end else memAck = 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (wbValid && wbReady) acc_cyc = cyc;
        if (memReq && exp_q.size() > 0 && !memAck) begin
          e = exp_q[0];
          chk("stall_addr", memAddr, e.addr);
          chk("stall_data", memWData, e.data);
        end
        if (memReq && memAck) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_word: addr 0x%08h data 0x%08h, none expected", memAddr, memWData);
          end else begin
            e = exp_q.pop_front();
            chk("mem_addr", memAddr, e.addr);
            chk("mem_wdata", memWData, e.data);
            chk("mem_last", 32'(memLast), 32'(e.last));
          end
        end
        if (wbDone) begin
          chk("done_wbready", 32'(wbReady), 32'd0);
          if (lat_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_done: wbDone=1 at cycle %0d, none expected", cyc);
          end else begin
            chk("done_latency", 32'(cyc - acc_cyc + 1), 32'(lat_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] blk;
    bit ok;

    reset = 1'b0; wbValid = 1'b0; wbBlock = '0; wbTag = '0; wbSet = '0;

    // Reset state
    #6;
    chk("rst_wbready", 32'(wbReady), 32'd1);
    chk("rst_memreq", 32'(memReq), 32'd0);
    chk("rst_memaddr", memAddr, 32'd0);
    chk("rst_memwdata", memWData, 32'd0);
    #6 reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_wbready", 32'(wbReady), 32'd1);
    chk("idle_memreq", 32'(memReq), 32'd0);
    chk("idle_wbdone", 32'(wbDone), 32'd0);
    chk("idle_wberror", 32'(wbError), 32'd0);
    chk("idle_memlast", 32'(memLast), 32'd0);

    // Full line, ack held: addr 0x00..0x3C, data 0..15, done 18 cycles incl. accept
    for (int i = 0; i < 16; i++) begin
      blk[32*i +: 32] = 32'(i);
      push_exp(32'(4 * i), 32'(i), i == 15);
    end
    lat_q.push_back(18);
    send_line(25'h0, 1'b0, blk);
    wait_drain();

    // Address generation: all-ones tag/set/data
    for (int i = 0; i < 16; i++)
      push_exp(32'hFFFF_FFC0 + 32'(4 * i), 32'hFFFF_FFFF, i == 15);
    lat_q.push_back(18);
    send_line(25'h1FF_FFFF, 1'b1, {512{1'b1}});
    wait_drain();

    // Stall on word 5 for 3 cycles: tag 0x123 set 1 -> base 0x91C0
    for (int i = 0; i < 16; i++) begin
      blk[32*i +: 32] = 32'hA500_0000 + 32'(i);
      push_exp(32'h0000_91C0 + 32'(4 * i), 32'hA500_0000 + 32'(i), i == 15);
    end
    lat_q.push_back(21);
    stall_word = 4'd5;
    stall_left = 3;
    send_line(25'h123, 1'b1, blk);
    wait_drain();

    // Busy then reset mid-line: tag 2 set 0 -> base 0x100
    for (int i = 0; i < 16; i++) begin
      blk[32*i +: 32] = 32'h0000_0100 + 32'(i);
      push_exp(32'h0000_0100 + 32'(4 * i), 32'h0000_0100 + 32'(i), i == 15);
    end
    lat_q.push_back(18);
    send_line(25'h2, 1'b0, blk);
    wbTag = 25'h3; wbBlock = ~blk; wbValid = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("busy_wbready", 32'(wbReady), 32'd0);
    end
    wbValid = 1'b0;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #2;
      if (memReq && memAddr[5:2] == 4'd8) begin ok = 1; break; end
    end
    chk("reach_word8", 32'(ok), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_memreq", 32'(memReq), 32'd0);
    chk("abort_wbdone", 32'(wbDone), 32'd0);
    chk("abort_wbready", 32'(wbReady), 32'd1);
    chk("abort_remaining", 32'(exp_q.size()), 32'd8);
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (25) @(posedge clk);

    // Next line after reset starts at word 0: tag 3 set 0 -> base 0x180
    for (int i = 0; i < 16; i++) begin
      blk[32*i +: 32] = 32'h0BAD_0000 + 32'(i);
      push_exp(32'h0000_0180 + 32'(4 * i), 32'h0BAD_0000 + 32'(i), i == 15);
    end
    lat_q.push_back(18);
    send_line(25'h3, 1'b0, blk);
    wait_drain();

`ifdef CACHE_WB_TIMEOUT_EN
    // Timeout with TIMEOUT=4 and no acks
    ack_off = 1'b1;
    send_line(25'h4, 1'b0, blk);
    chk("to_memreq_c1", 32'(memReq), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("to_memreq_c4", 32'(memReq), 32'd1);
    chk("to_wberror_c4", 32'(wbError), 32'd0);
    @(posedge clk); #1;
    chk("to_wberror", 32'(wbError), 32'd1);
    chk("to_wbready", 32'(wbReady), 32'd1);
    chk("to_memreq", 32'(memReq), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("to_wberror_sticky", 32'(wbError), 32'd1);
    ack_off = 1'b0;
`else
    chk("wberror_tied", 32'(wbError), 32'd0);
`endif

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
